// File: rtl/uv_spi_rxq_ctrl.sv
// SPI RX queue controller: shifter enqueue, drop accounting, bus reads, irq.
// Optional idle timeout interrupt: define UV_SPI_RXQ_CTRL_TIMEOUT_EN.
module uv_spi_rxq_ctrl #(
    parameter int QUE_AW = 3,
    parameter int QUE_DW = 32,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_vld,
    input  logic [QUE_DW-1:0] rx_dat,
    output logic              q_enq_vld,
    output logic [QUE_DW-1:0] q_enq_dat,
    input  logic              q_enq_rdy,
    output logic              q_deq_vld,
    input  logic              q_deq_rdy,
    input  logic [QUE_DW-1:0] q_deq_dat,
    output logic              q_clr,
    input  logic [QUE_AW:0]   q_len,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [QUE_DW-1:0] rd_dat,
    output logic              rd_err,
    input  logic              cfg_en,
    input  logic [QUE_AW:0]   cfg_wm,
    input  logic [TMO_W-1:0]  cfg_tmo,
    input  logic              cmd_clr,
    input  logic              ovf_clr,
    output logic              ovf,
    output logic [7:0]        drop_cnt,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   clr_pend;
    logic   rd_take;
    logic   drop;
    logic   wm_hit;
    logic   tmo_flag;

    assign q_enq_vld = rx_vld & cfg_en & (state != CLR);
    assign q_enq_dat = rx_dat;
    assign drop      = rx_vld & cfg_en & (~q_enq_rdy | (state == CLR));
    assign rd_ack    = (state == RESP);
    assign q_clr     = (state == CLR);
    assign wm_hit    = (cfg_wm != '0) && (q_len >= cfg_wm);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state, pop strobe; a flush always wins over a read
    always_comb begin
        state_nxt = state;
        q_deq_vld = 1'b0;
        rd_take   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_clr | clr_pend) begin
                    state_nxt = CLR;
                end else if (rd_req) begin
                    rd_take   = 1'b1;
                    q_deq_vld = q_deq_rdy;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            CLR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // remember a flush requested while a response is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           clr_pend <= 1'b0;
        else if (state == RESP && cmd_clr) clr_pend <= 1'b1;
        else if (state == IDLE)            clr_pend <= 1'b0;
    end

    // capture read data, or flag an empty-queue read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dat <= '0;
            rd_err <= 1'b0;
        end else if (rd_take) begin
            rd_dat <= q_deq_rdy ? q_deq_dat : '0;
            rd_err <= ~q_deq_rdy;
        end
    end

    // sticky overflow and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef UV_SPI_RXQ_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_rst;

    assign tmo_rst = rx_vld | q_deq_vld | q_clr | ~q_deq_rdy;

    // idle counter runs while data sits unread in the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          tmo_cnt <= '0;
        else if (tmo_rst) tmo_cnt <= '0;
        else if (cfg_tmo != '0 && !tmo_flag)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // timeout flag holds until the queue is popped or flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    tmo_flag <= 1'b0;
        else if (q_deq_vld | q_clr) tmo_flag <= 1'b0;
        else if (cfg_tmo != '0 && tmo_cnt == cfg_tmo)
            tmo_flag <= 1'b1;
    end
`else
    logic tmo_unused;

    assign tmo_flag   = 1'b0;
    assign tmo_unused = ^cfg_tmo;
`endif

    // registered interrupt, one cycle behind its sources
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= wm_hit | ovf | tmo_flag;
    end

endmodule

// File: tb/tb_uv_spi_rxq_ctrl.sv
// Bench for uv_spi_rxq_ctrl with a behavioural 8-entry queue.
// Read responses are checked by a scoreboard monitor on rd_ack.
module tb_uv_spi_rxq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_vld;
    logic [31:0] rx_dat;
    logic        q_enq_vld;
    logic [31:0] q_enq_dat;
    logic        q_enq_rdy;
    logic        q_deq_vld;
    logic        q_deq_rdy;
    logic [31:0] q_deq_dat;
    logic        q_clr;
    logic [3:0]  q_len;
    logic        rd_req;
    logic        rd_ack;
    logic [31:0] rd_dat;
    logic        rd_err;
    logic        cfg_en;
    logic [3:0]  cfg_wm;
    logic [7:0]  cfg_tmo;
    logic        cmd_clr;
    logic        ovf_clr;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        irq;

    always #5 clk = ~clk;

    uv_spi_rxq_ctrl #(.QUE_AW(3), .QUE_DW(32), .TMO_W(8)) dut (
        .clk(clk), .rst(rst),
        .rx_vld(rx_vld), .rx_dat(rx_dat),
        .q_enq_vld(q_enq_vld), .q_enq_dat(q_enq_dat),
        .q_enq_rdy(q_enq_rdy),
        .q_deq_vld(q_deq_vld), .q_deq_rdy(q_deq_rdy),
        .q_deq_dat(q_deq_dat),
        .q_clr(q_clr), .q_len(q_len),
        .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_dat(rd_dat), .rd_err(rd_err),
        .cfg_en(cfg_en), .cfg_wm(cfg_wm), .cfg_tmo(cfg_tmo),
        .cmd_clr(cmd_clr), .ovf_clr(ovf_clr),
        .ovf(ovf), .drop_cnt(drop_cnt), .irq(irq)
    );

    logic [31:0] qm [8];
    logic [2:0]  hd;
    logic [2:0]  tl;
    logic [3:0]  cnt;
    logic        enq_ok;
    logic        deq_ok;

    assign q_enq_rdy = (cnt != 4'd8);
    assign q_deq_rdy = (cnt != 4'd0);
    assign q_deq_dat = qm[hd];
    assign q_len     = cnt;
    assign enq_ok    = q_enq_vld & q_enq_rdy;
    assign deq_ok    = q_deq_vld & q_deq_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else if (q_clr) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            if (enq_ok) begin
                qm[tl] <= q_enq_dat;
                tl     <= tl + 3'd1;
            end
            if (deq_ok) hd <= hd + 3'd1;
            cnt <= cnt + 4'(enq_ok) - 4'(deq_ok);
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ack_seen = 0;
    int   clr_seen = 0;

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && q_clr) clr_seen++;
        if (!rst && rd_ack) begin
            ack_seen++;
            if (sb.size() == 0) begin
                chk("rd_unexp_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_dat", rd_dat, e.dat);
                chk("rd_err", 32'(rd_err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [31:0] d);
        rx_vld = 1'b1;
        rx_dat = d;
        tick();
        rx_vld = 1'b0;
    endtask

    task automatic rd(logic e, logic [31:0] d);
        bit got;
        got = 1'b0;
        sb.push_back('{err: e, dat: d});
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            tick();
        end else begin
            chk("rd_timeout", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        rd_req = 1'b0;
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int a0;
        int k;
        rst = 1'b1;
        rx_vld = 1'b0; rx_dat = '0; rd_req = 1'b0;
        cfg_en = 1'b1; cfg_wm = '0; cfg_tmo = '0;
        cmd_clr = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_rd_ack", 32'(rd_ack), 0);
        chk("rst_rd_dat", rd_dat, 0);
        chk("rst_rd_err", 32'(rd_err), 0);
        chk("rst_q_deq_vld", 32'(q_deq_vld), 0);
        chk("rst_q_clr", 32'(q_clr), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_irq", 32'(irq), 0);
        rst = 1'b0;
        tick();

        for (int i = 1; i <= 3; i++) send(32'hA5A5_0000 + i);
        rd(1'b0, 32'hA5A5_0001);
        rd(1'b0, 32'hA5A5_0002);
        rd(1'b0, 32'hA5A5_0003);
        rd(1'b1, 32'h0);

        for (int i = 0; i < 10; i++) send(32'h100 + i);
        tick();
        chk("full_ovf", 32'(ovf), 1);
        chk("full_drop_cnt", 32'(drop_cnt), 2);
        chk("full_irq", 32'(irq), 1);
        pulse_ovf_clr();
        chk("clr_ovf", 32'(ovf), 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 0);
        tick();
        chk("clr_irq", 32'(irq), 0);
        for (int i = 0; i < 8; i++) rd(1'b0, 32'h100 + i);
        rd(1'b1, 32'h0);

        cfg_wm = 4'd4;
        for (int i = 1; i <= 3; i++) begin
            send(32'h40 + i);
            chk("wm_irq_low", 32'(irq), 0);
        end
        tick();
        chk("wm_irq_low3", 32'(irq), 0);
        send(32'h44);
        chk("wm_irq_lag", 32'(irq), 0);
        tick();
        chk("wm_irq_high", 32'(irq), 1);
        rd(1'b0, 32'h41);
        chk("wm_irq_drop", 32'(irq), 0);
        rd(1'b0, 32'h42);
        rd(1'b0, 32'h43);
        rd(1'b0, 32'h44);
        cfg_wm = '0;

        for (int i = 1; i <= 5; i++) send(32'h500 + i);
        c0 = clr_seen;
        a0 = ack_seen;
        cmd_clr = 1'b1;
        rd_req = 1'b1;
        tick();
        cmd_clr = 1'b0;
        rd_req = 1'b0;
        repeat (4) tick();
        chk("clr_pulses", 32'(clr_seen - c0), 1);
        chk("clr_no_ack", 32'(ack_seen - a0), 0);
        rd(1'b1, 32'h0);

        send(32'h511);
        send(32'h512);
        c0 = clr_seen;
        sb.push_back('{err: 1'b0, dat: 32'h511});
        rd_req = 1'b1;
        tick();
        chk("resp_ack", 32'(rd_ack), 1);
        cmd_clr = 1'b1;
        rd_req = 1'b0;
        tick();
        cmd_clr = 1'b0;
        repeat (4) tick();
        chk("late_clr_pulses", 32'(clr_seen - c0), 1);
        rd(1'b1, 32'h0);

        for (int i = 0; i < 8; i++) send(32'h600 + i);
        pulse_ovf_clr();
        sb.push_back('{err: 1'b0, dat: 32'h600});
        rd_req = 1'b1;
        rx_vld = 1'b1;
        rx_dat = 32'h6FF;
        tick();
        rx_vld = 1'b0;
        tick();
        rd_req = 1'b0;
        chk("pop_full_drop", 32'(drop_cnt), 1);
        send(32'h608);
        pulse_ovf_clr();
        rx_vld = 1'b1;
        rx_dat = 32'hDEAD;
        repeat (300) tick();
        chk("sat_drop_cnt", 32'(drop_cnt), 255);
        chk("sat_ovf", 32'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        rx_vld = 1'b0;
        chk("race_drop_cnt", 32'(drop_cnt), 1);
        chk("race_ovf", 32'(ovf), 1);
        rd(1'b0, 32'h601);
        cmd_clr = 1'b1;
        tick();
        cmd_clr = 1'b0;
        repeat (2) tick();
        pulse_ovf_clr();

        cfg_en = 1'b0;
        send(32'h900);
        send(32'h901);
        chk("dis_drop_cnt", 32'(drop_cnt), 0);
        chk("dis_ovf", 32'(ovf), 0);
        rd(1'b1, 32'h0);
        cfg_en = 1'b1;
        tick();

`ifdef UV_SPI_RXQ_CTRL_TIMEOUT_EN
        cfg_tmo = 8'd16;
        send(32'h700);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (irq) begin
                k = i;
                break;
            end
        end
        chk("tmo_latency_ok", 32'(k >= 17 && k <= 18), 1);
        rd(1'b0, 32'h700);
        chk("tmo_irq_clear", 32'(irq), 0);
        cfg_tmo = '0;
`else
        cfg_tmo = 8'd16;
        send(32'h700);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (irq) k++;
        end
        chk("notmo_irq_cycles", 32'(k), 0);
        rd(1'b0, 32'h700);
        cfg_tmo = '0;
`endif

        send(32'h800);
        a0 = ack_seen;
        rd_req = 1'b1;
        #3;
        rst = 1'b1;
        #30;
        rd_req = 1'b0;
        #10;
        rst = 1'b0;
        repeat (3) tick();
        chk("rstmid_no_ack", 32'(ack_seen - a0), 0);
        chk("rstmid_rd_err", 32'(rd_err), 0);
        chk("rstmid_q_len", 32'(q_len), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
